// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter and multiplexed SysBus cycle sequencer.
// Every output is registered from the next state, so strobes change only on clock edges.
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 0,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Write0,
  input  logic              Write1,
  input  logic [DATA_W-1:0] Addr0,
  input  logic [DATA_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Done0,
  output logic              Done1,
  output logic [DATA_W-1:0] RData,
  output logic [DATA_W-1:0] SysBusOut,
  output logic              SysBusEn,
  input  logic [DATA_W-1:0] SysBusIn,
  output logic              ALE,
  output logic              nME,
  output logic              nOE,
  output logic              nWE,
  output logic              ENB,
  output logic              Busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {IDLE, ADDR, STRB, CAPT, DONE} state_t;

  state_t            state, nextState;
  logic [3:0]        waitCnt, nextCnt;
  logic              lastId, nextLast;
  logic              accWrite, latchWrite;
  logic              accId, latchId;
  logic [DATA_W-1:0] accAddr, latchAddr;
  logic [DATA_W-1:0] accWData, latchWData;

  logic              gnt0Nxt, gnt1Nxt, done0Nxt, done1Nxt;
  logic              aleNxt, nMeNxt, nOeNxt, nWeNxt, enbNxt, busEnNxt, busyNxt;
  logic [DATA_W-1:0] busOutNxt;

  always_comb begin
    nextState  = state;
    nextCnt    = waitCnt;
    nextLast   = lastId;
    latchWrite = accWrite;
    latchId    = accId;
    latchAddr  = accAddr;
    latchWData = accWData;

    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          // On a tie the requester that was not served last wins.
          latchId    = (Req0 && Req1) ? ~lastId : Req1;
          latchWrite = latchId ? Write1 : Write0;
          latchAddr  = latchId ? Addr1  : Addr0;
          latchWData = latchId ? WData1 : WData0;
          nextState  = ADDR;
        end
      end
      ADDR: begin
        nextState = STRB;
        nextCnt   = WAIT_LOAD;
      end
      STRB: begin
        if (waitCnt == 4'd0) nextState = CAPT;
        else                 nextCnt   = waitCnt - 4'd1;
      end
      CAPT: nextState = DONE;
      DONE: begin
        nextLast  = accId;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    gnt0Nxt   = 1'b0;
    gnt1Nxt   = 1'b0;
    done0Nxt  = 1'b0;
    done1Nxt  = 1'b0;
    aleNxt    = 1'b0;
    nMeNxt    = 1'b1;
    nOeNxt    = 1'b1;
    nWeNxt    = 1'b1;
    enbNxt    = 1'b0;
    busEnNxt  = 1'b0;
    busOutNxt = '0;
    busyNxt   = (nextState != IDLE);

    case (nextState)
      ADDR: begin
        aleNxt    = 1'b1;
        busEnNxt  = 1'b1;
        busOutNxt = latchAddr;
        gnt0Nxt   = ~latchId;
        gnt1Nxt   = latchId;
      end
      STRB: begin
        nMeNxt = 1'b0;
        if (latchWrite) begin
          nWeNxt    = 1'b0;
          busEnNxt  = 1'b1;
          busOutNxt = latchWData;
        end else begin
          nOeNxt = 1'b0;
        end
      end
      CAPT: begin
        nMeNxt = 1'b0;
        // Write data stays on the pads one cycle past the nWE rising edge.
        if (latchWrite) begin
          busEnNxt  = 1'b1;
          busOutNxt = latchWData;
        end else begin
          nOeNxt = 1'b0;
          enbNxt = 1'b1;
        end
      end
      DONE: begin
        done0Nxt = ~latchId;
        done1Nxt = latchId;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      lastId    <= 1'b1;
      accWrite  <= 1'b0;
      accId     <= 1'b0;
      accAddr   <= '0;
      accWData  <= '0;
      RData     <= '0;
      Gnt0      <= 1'b0;
      Gnt1      <= 1'b0;
      Done0     <= 1'b0;
      Done1     <= 1'b0;
      ALE       <= 1'b0;
      nME       <= 1'b1;
      nOE       <= 1'b1;
      nWE       <= 1'b1;
      ENB       <= 1'b0;
      SysBusEn  <= 1'b0;
      SysBusOut <= '0;
      Busy      <= 1'b0;
    end else begin
      state     <= nextState;
      waitCnt   <= nextCnt;
      lastId    <= nextLast;
      accWrite  <= latchWrite;
      accId     <= latchId;
      accAddr   <= latchAddr;
      accWData  <= latchWData;
      if (state == CAPT && !accWrite) RData <= SysBusIn;
      Gnt0      <= gnt0Nxt;
      Gnt1      <= gnt1Nxt;
      Done0     <= done0Nxt;
      Done1     <= done1Nxt;
      ALE       <= aleNxt;
      nME       <= nMeNxt;
      nOE       <= nOeNxt;
      nWE       <= nWeNxt;
      ENB       <= enbNxt;
      SysBusEn  <= busEnNxt;
      SysBusOut <= busOutNxt;
      Busy      <= busyNxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance 0 uses WAIT_CYCLES=0, instance 1 uses WAIT_CYCLES=2.
// A timeline model per instance is compared every cycle; directed literals pin the model.
module tb_mem_bus_arbiter;

  logic        Clock;
  logic        nReset;
  logic        req0 [2], req1 [2], wr0 [2], wr1 [2];
  logic [15:0] addr0 [2], addr1 [2], wd0 [2], wd1 [2], busIn [2];
  logic        gnt0 [2], gnt1 [2], done0 [2], done1 [2];
  logic [15:0] rdata [2], busOut [2];
  logic        busEn [2], ale [2], nme [2], noe [2], nwe [2], enb [2], busy [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  for (genvar g = 0; g < 2; g++) begin : gInst
    mem_bus_arbiter #(.WAIT_CYCLES(2 * g), .DATA_W(16)) dut (
      .Clock(Clock), .nReset(nReset),
      .Req0(req0[g]), .Req1(req1[g]), .Write0(wr0[g]), .Write1(wr1[g]),
      .Addr0(addr0[g]), .Addr1(addr1[g]), .WData0(wd0[g]), .WData1(wd1[g]),
      .Gnt0(gnt0[g]), .Gnt1(gnt1[g]), .Done0(done0[g]), .Done1(done1[g]),
      .RData(rdata[g]), .SysBusOut(busOut[g]), .SysBusEn(busEn[g]), .SysBusIn(busIn[g]),
      .ALE(ale[g]), .nME(nme[g]), .nOE(noe[g]), .nWE(nwe[g]), .ENB(enb[g]), .Busy(busy[g])
    );
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic chkBit(input string name, input int inst, input logic act, input logic exp);
    chk(name, inst, {15'd0, act}, {15'd0, exp});
  endtask

  // Model: position within the access timeline (0 = idle, 1 = address phase, ...).
  int          pos [2];
  logic        mId [2], mLast [2], mWrite [2];
  logic [15:0] mAddr [2], mWData [2], mRData [2];

  function automatic logic winner(int i);
    return (req0[i] && req1[i]) ? !mLast[i] : req1[i];
  endfunction

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 2; i++) begin
        pos[i] <= 0; mLast[i] <= 1'b1; mId[i] <= 1'b0; mWrite[i] <= 1'b0;
        mAddr[i] <= 16'd0; mWData[i] <= 16'd0; mRData[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pos[i] == 0) begin
          if (req0[i] || req1[i]) begin
            mId[i]    <= winner(i);
            mWrite[i] <= winner(i) ? wr1[i] : wr0[i];
            mAddr[i]  <= winner(i) ? addr1[i] : addr0[i];
            mWData[i] <= winner(i) ? wd1[i] : wd0[i];
            pos[i]    <= 1;
          end
        end else if (pos[i] == 4 + 2 * i) begin
          mLast[i] <= mId[i];
          pos[i]   <= 0;
        end else begin
          if (pos[i] == 3 + 2 * i && !mWrite[i]) mRData[i] <= busIn[i];
          pos[i] <= pos[i] + 1;
        end
      end
    end
  end

  function automatic logic [15:0] expCtl(int i);
    int w, p;
    logic g0, g1, d0, d1, al, me, oe, we, en, be;
    w = 2 * i; p = pos[i];
    g0 = 0; g1 = 0; d0 = 0; d1 = 0; al = 0; me = 1; oe = 1; we = 1; en = 0; be = 0;
    if (p == 1) begin
      al = 1; be = 1;
      if (mId[i]) g1 = 1; else g0 = 1;
    end else if (p >= 2 && p <= 2 + w) begin
      me = 0;
      if (mWrite[i]) begin we = 0; be = 1; end else oe = 0;
    end else if (p == 3 + w) begin
      me = 0;
      if (mWrite[i]) be = 1; else begin oe = 0; en = 1; end
    end else if (p == 4 + w) begin
      if (mId[i]) d1 = 1; else d0 = 1;
    end
    return {5'd0, g0, g1, d0, d1, al, me, oe, we, en, be, (p != 0)};
  endfunction

  function automatic logic [15:0] expBus(int i);
    if (pos[i] == 1) return mAddr[i];
    if (mWrite[i] && pos[i] >= 2 && pos[i] <= 3 + 2 * i) return mWData[i];
    return 16'd0;
  endfunction

  function automatic logic [15:0] actCtl(int i);
    return {5'd0, gnt0[i], gnt1[i], done0[i], done1[i], ale[i], nme[i], noe[i], nwe[i],
            enb[i], busEn[i], busy[i]};
  endfunction

  always @(negedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      chk("ctl", i, actCtl(i), expCtl(i));
      chk("busOut", i, busOut[i], expBus(i));
      chk("rdata", i, rdata[i], mRData[i]);
    end
  end

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 40 && (busy[0] || busy[1]); n++) step();
    chkBit("idleTimeout", 0, busy[0] | busy[1], 1'b0);
  endtask

  int gCyc [8], gId [8], dCyc [8], dId [8];
  int gN, dN;

  initial begin
    nReset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 0; req1[i] = 0; wr0[i] = 0; wr1[i] = 0;
      addr0[i] = 0; addr1[i] = 0; wd0[i] = 0; wd1[i] = 0; busIn[i] = 0;
    end
    #1 nReset = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("resetCtl", i, actCtl(i), 16'h0038);
      chk("resetBus", i, busOut[i], 16'h0000);
      chk("resetRData", i, rdata[i], 16'h0000);
    end
    step(); step();
    nReset = 1'b1;

    // Single read on instance 0.
    addr0[0] = 16'h0040; wr0[0] = 0; busIn[0] = 16'hBEEF; req0[0] = 1;
    step();
    chkBit("rdALE", 0, ale[0], 1); chk("rdAddr", 0, busOut[0], 16'h0040);
    chkBit("rdGnt0", 0, gnt0[0], 1);
    req0[0] = 0;
    step(); chkBit("rdNME2", 0, nme[0], 0); chkBit("rdNOE2", 0, noe[0], 0);
    step(); chkBit("rdNME3", 0, nme[0], 0); chkBit("rdNOE3", 0, noe[0], 0); chkBit("rdENB", 0, enb[0], 1);
    step(); chkBit("rdDone0", 0, done0[0], 1); chk("rdData", 0, rdata[0], 16'hBEEF);
    step(); chkBit("rdBusy", 0, busy[0], 0);

    // Single write on instance 1.
    addr1[1] = 16'h1234; wd1[1] = 16'h00FF; wr1[1] = 1; busIn[1] = 16'hA5A5; req1[1] = 1;
    step();
    chkBit("wrALE", 1, ale[1], 1); chk("wrAddr", 1, busOut[1], 16'h1234); chkBit("wrGnt1", 1, gnt1[1], 1);
    req1[1] = 0;
    for (int n = 0; n < 3; n++) begin
      step(); chkBit("wrNWE", 1, nwe[1], 0); chk("wrData", 1, busOut[1], 16'h00FF);
    end
    step(); chkBit("wrHoldNWE", 1, nwe[1], 1); chkBit("wrHoldEn", 1, busEn[1], 1);
    chk("wrHoldData", 1, busOut[1], 16'h00FF);
    step(); chkBit("wrDone1", 1, done1[1], 1); chk("wrRData", 1, rdata[1], 16'h0000);
    waitIdle();

    nReset = 1'b0; step(); nReset = 1'b1;

    // Contention on instance 0.
    addr0[0] = 16'h0100; addr1[0] = 16'h0200; wr0[0] = 0; wr1[0] = 0; busIn[0] = 16'h1111;
    req0[0] = 1; req1[0] = 1; gN = 0; dN = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if ((gnt0[0] || gnt1[0]) && gN < 8) begin gCyc[gN] = n; gId[gN] = int'(gnt1[0]); gN++; end
      if ((done0[0] || done1[0]) && dN < 8) begin dCyc[dN] = n; dId[dN] = int'(done1[0]); dN++; end
      if (n == 16) begin req0[0] = 0; req1[0] = 0; end
    end
    chk("ctGntCount", 0, 16'(gN), 16'd4);
    chk("ctDoneCount", 0, 16'(dN), 16'd4);
    for (int j = 0; j < 4 && j < gN && j < dN; j++) begin
      chk("ctGntCyc", 0, 16'(gCyc[j]), 16'(1 + 5 * j));
      chk("ctGntId", 0, 16'(gId[j]), 16'(j % 2));
      chk("ctDoneCyc", 0, 16'(dCyc[j]), 16'(4 + 5 * j));
      chk("ctDoneId", 0, 16'(dId[j]), 16'(j % 2));
    end
    waitIdle();

    // Late arrival of requester 1 during requester 0's strobe.
    addr0[0] = 16'h0300; req0[0] = 1;
    step(); chkBit("laGnt0", 0, gnt0[0], 1); req0[0] = 0;
    step(); req1[0] = 1;
    step();
    step(); chkBit("laDone0", 0, done0[0], 1); chkBit("laNoGnt1a", 0, gnt1[0], 0);
    step(); chkBit("laIdle", 0, busy[0], 0); chkBit("laNoGnt1b", 0, gnt1[0], 0);
    step(); chkBit("laGnt1", 0, gnt1[0], 1); req1[0] = 0;
    waitIdle();

    // Reset during the strobe of a write on instance 1.
    addr1[1] = 16'h0ABC; wd1[1] = 16'h5555; wr1[1] = 1; req1[1] = 1;
    step(); chkBit("rsGnt1", 1, gnt1[1], 1); req1[1] = 0;
    step(); chkBit("rsNWElow", 1, nwe[1], 0);
    @(posedge Clock); #2 nReset = 1'b0; #1;
    chkBit("rsNWE", 1, nwe[1], 1); chkBit("rsBusEn", 1, busEn[1], 0);
    chkBit("rsBusy", 1, busy[1], 0); chkBit("rsNoDone", 1, done1[1], 0);
    step();
    nReset = 1'b1;
    wr0[1] = 0; wr1[1] = 0; addr0[1] = 16'h0007; addr1[1] = 16'h0008; req0[1] = 1; req1[1] = 1;
    step(); chkBit("rsTieGnt0", 1, gnt0[1], 1); chkBit("rsTieGnt1", 1, gnt1[1], 0);
    req0[1] = 0; req1[1] = 0;
    waitIdle();

    // Early drop of Req0 right after its grant.
    addr0[0] = 16'h0040; wr0[0] = 0; busIn[0] = 16'h2468; req0[0] = 1;
    step(); chkBit("edGnt0", 0, gnt0[0], 1); req0[0] = 0;
    step(); step();
    step(); chkBit("edDone0", 0, done0[0], 1); chk("edRData", 0, rdata[0], 16'h2468);
    for (int n = 0; n < 6; n++) begin
      step(); chkBit("edNoGnt", 0, gnt0[0] | gnt1[0], 0); chkBit("edNoBusy", 0, busy[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and bus-cycle sequencer for the shared external memory bus. Requester 0 (the CPU control unit) and requester 1 (DMA/debug port) each present a single-word read or write request. The block grants the bus round-robin and drives the multiplexed address/data SysBus and the ALE/nME/nOE/nWE/ENB strobes through a fixed phase sequence. It returns read data and a completion pulse to the granted requester.

## Interface
- WAIT_CYCLES, 0, extra STRB cycles inserted per access (0..15)
- Clock  in  1  system clock, all state updates on rising edge
- nReset  in  1  asynchronous, active-low reset
- Req0, Req1  in  1 each  level request from requester 0 / 1
- Write0, Write1  in  1 each  1 = write, 0 = read; latched at grant
- Addr0, Addr1  in  16 each  word address; latched at grant
- WData0, WData1  in  16 each  write data; latched at grant
- Gnt0, Gnt1  out  1 each  one-cycle pulse: request accepted
- Done0, Done1  out  1 each  one-cycle pulse: access complete
- RData  out  16  last read data; valid in Done cycle, held until next read capture
- SysBusOut  out  16  multiplexed address/data to pads
- SysBusEn  out  1  pad drive enable for SysBusOut
- SysBusIn  in  16  data from pads
- ALE  out  1  address latch enable, active high
- nME, nOE, nWE  out  1 each  memory enable, output enable, write enable; all active low
- ENB  out  1  read-data buffer enable, active high
- Busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ADDR, STRB, CAPT, DONE.
- IDLE: if any Req is high, pick a winner, latch its Write/Addr/WData and id, and go to ADDR. Otherwise stay in IDLE.
- Arbitration: single request wins outright. If both are high, the requester not served last wins. The last-served pointer resets to 1, so requester 0 wins the first tie.
- ADDR (1 cycle): SysBusOut = Addr, SysBusEn = 1, ALE = 1, Gnt<id> = 1.
- STRB (1 + WAIT_CYCLES cycles, via a 4-bit down-counter loaded on entry): nME = 0.
  - Read: nOE = 0, SysBusEn = 0.
  - Write: nWE = 0, SysBusOut = WData, SysBusEn = 1.
- CAPT (1 cycle): nME = 0.
  - Read: nOE = 0, ENB = 1; RData loads SysBusIn on the edge leaving CAPT.
  - Write: nWE = 1, SysBusOut = WData, SysBusEn = 1 (data hold).
- DONE (1 cycle): all strobes idle, Done<id> = 1, update the last-served pointer, return to IDLE.
- Idle strobe values: ALE = 0, nME = 1, nOE = 1, nWE = 1, ENB = 0, SysBusEn = 0, SysBusOut = 0.
- Requester protocol:
  - Req is sampled only in IDLE.
  - Req may drop any time after Gnt; dropping it does not abort the access.
  - Holding Req high through Done requests a back-to-back access, which is subject to round-robin.
- All outputs are registered. Strobes never glitch between phases.

## Timing
- Reset values: state IDLE, all strobes idle, Gnt*/Done*/Busy = 0, RData = 0, counter = 0, pointer = 1.
- Reset assertion mid-access forces all of the above immediately, without waiting for a clock. The access is dropped and no Done is issued.
- With Req high at rising edge k, in IDLE:
  - ADDR/Gnt in cycle k+1.
  - STRB in cycles k+2 .. k+2+WAIT_CYCLES.
  - CAPT next, then DONE.
  - Done cycle = k+4+WAIT_CYCLES. Total occupancy 4+WAIT_CYCLES cycles.
- Minimum spacing between Gnt pulses is 5+WAIT_CYCLES cycles (one IDLE cycle between accesses).
- Gnt and Done never assert for both ids in the same cycle, and are never both high in one cycle.
- A Req arriving during a non-IDLE state waits. It is never lost while held.
- Write0/Addr0/WData0 changes after grant have no effect on the current access.

## Test plan
- Single read, WAIT_CYCLES = 0: Req0 = 1, Addr0 = 16'h0040; SysBusIn = 16'hBEEF in CAPT.
  - Expect SysBusOut = 16'h0040 with ALE = 1 in cycle k+1.
  - Expect nME = nOE = 0 in cycles k+2..k+3.
  - Expect Done0 and RData = 16'hBEEF in cycle k+4.
- Single write, WAIT_CYCLES = 2: Req1 = 1, Addr1 = 16'h1234, WData1 = 16'h00FF.
  - Expect nWE = 0 for 3 cycles with SysBusOut = 16'h00FF.
  - Expect data held in CAPT and Done1 at k+6.
  - RData is unchanged.
- Contention: Req0 = Req1 = 1 held continuously.
  - Expect grants in order 0, 1, 0, 1, each 5 cycles apart.
  - Done pulses alternate.
- Late arrival: Req1 rises during requester 0's STRB.
  - Expect requester 0 to finish undisturbed.
  - Expect Gnt1 one cycle after IDLE is re-entered.
- Reset mid-access: assert nReset = 0 during STRB of a write.
  - Expect nWE = 1, SysBusEn = 0 and Busy = 0 immediately, with no Done.
  - After release, the first tie goes to requester 0.
- Early drop: Req0 deasserted in the cycle after Gnt0.
  - Expect the access completes with Done0.
  - Expect no second grant.
